// File: rtl/ring_buffer_pkg.sv
// Shared definitions for ring_buffer and its read-side streamer.
package ring_buffer_pkg;

  // Depth of the streamer's output store; also the cap on outstanding reads.
  localparam int unsigned StoreDepth = 2;

  // Holds count + in_flight, range 0..StoreDepth.
  typedef logic [1:0] fill_t;

endpackage

// File: rtl/ring_buffer_streamer_skid_store.sv
// Two-entry FIFO-ordered register pair; entry0 is the head.
module skid_store
  import ring_buffer_pkg::*;
#(
  parameter int unsigned WordLengthBits = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WordLengthBits-1:0] push_data,
  input  logic                      pop,
  output fill_t                     count,
  output logic [WordLengthBits-1:0] head
);

  logic [WordLengthBits-1:0] entry0;
  logic [WordLengthBits-1:0] entry1;
  fill_t                     count_q;
  logic                      do_pop;

  assign do_pop = pop && (count_q != '0);
  assign count  = count_q;
  assign head   = entry0;

  // Push/pop update keeping FIFO order; the caller never pushes into a full store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry0  <= '0;
      entry1  <= '0;
      count_q <= '0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (count_q == '0) entry0 <= push_data;
          else               entry1 <= push_data;
          count_q <= count_q + fill_t'(1);
        end
        2'b01: begin
          entry0  <= entry1;
          count_q <= count_q - fill_t'(1);
        end
        2'b11: begin
          if (count_q == fill_t'(StoreDepth)) begin
            entry0 <= entry1;
            entry1 <= push_data;
          end else begin
            entry0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ring_buffer_streamer.sv
// Read-side adapter: turns ring_buffer get/data_out into a valid/ready stream.
module ring_buffer_streamer
  import ring_buffer_pkg::*;
#(
  parameter int unsigned WordLengthBits = 8,
  parameter int unsigned CountBits      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      buffer_empty,
  input  logic [WordLengthBits-1:0] buffer_data,
  output logic                      get,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [WordLengthBits-1:0] m_data,
  output logic [CountBits-1:0]      words_sent
);

  logic  in_flight;
  logic  pop;
  fill_t count;
  fill_t fill;

  assign m_valid = (count != '0);
  assign pop     = m_valid && m_ready;
  assign fill    = count + fill_t'(in_flight);

  // Read credit: a slot is free, or one is being freed by this cycle's pop.
  // Gated by rst so the strobe also reads 0 while reset is held.
  always_comb begin
    get = 1'b0;
    if (rst && enable && !buffer_empty &&
        ((fill < fill_t'(StoreDepth)) || pop)) begin
      get = 1'b1;
    end
  end

  // Track the one-cycle buffer read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) in_flight <= 1'b0;
    else      in_flight <= get;
  end

  // Count completed stream handshakes, wrapping naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     words_sent <= '0;
    else if (pop) words_sent <= words_sent + CountBits'(1);
  end

  skid_store #(
    .WordLengthBits(WordLengthBits)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .push      (in_flight),
    .push_data (buffer_data),
    .pop       (pop),
    .count     (count),
    .head      (m_data)
  );

endmodule
